// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
//   program counter and fetches over a req/gnt/rvalid memory handshake with
//   at most one request outstanding. Handles hazard freeze and branch redirect.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous reset, active low
//   i_freeze         hazard stall: a ready word is held, not consumed
//   i_branch_taken   redirect request from EX
//   i_branch_addr    redirect target
//   o_imem_req       fetch request valid
//   o_imem_addr      fetch address
//   i_imem_gnt       memory accepts the request this cycle
//   i_imem_rvalid    read data valid
//   i_imem_rdata     read data
//   o_pc             fetched address + 4 (0 during a bubble)
//   o_instruction    fetched word, or NOP_INSTR during a bubble
//   o_inst_valid     o_pc/o_instruction carry a real fetched word
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                    BIT_NUMBER = 32,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0,
    parameter logic [BIT_NUMBER-1:0] NOP_INSTR  = 32'hF000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_freeze,
    input  logic                  i_branch_taken,
    input  logic [BIT_NUMBER-1:0] i_branch_addr,
    output logic                  o_imem_req,
    output logic [BIT_NUMBER-1:0] o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [BIT_NUMBER-1:0] i_imem_rdata,
    output logic [BIT_NUMBER-1:0] o_pc,
    output logic [BIT_NUMBER-1:0] o_instruction,
    output logic                  o_inst_valid
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_READY} state_t;

    state_t                r_state;
    logic [BIT_NUMBER-1:0] r_pc_reg;
    logic [BIT_NUMBER-1:0] r_buf_pc;
    logic [BIT_NUMBER-1:0] r_buf_instr;
    logic                  r_kill;     // outstanding response belongs to a squashed path

    logic [BIT_NUMBER-1:0] w_buf_pc_inc;
    logic                  w_out_valid;

    // Modulo 2^BIT_NUMBER: the top word address wraps to 0.
    assign w_buf_pc_inc = r_buf_pc + BIT_NUMBER'(4);

    // A redirect in READY squashes the held word in the same cycle.
    assign w_out_valid = (r_state == S_READY) && !i_branch_taken;

    assign o_imem_req    = (r_state == S_FETCH);
    assign o_imem_addr   = r_pc_reg;
    assign o_inst_valid  = w_out_valid;
    assign o_instruction = w_out_valid ? r_buf_instr : NOP_INSTR;
    assign o_pc          = w_out_valid ? w_buf_pc_inc : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_FETCH;
            r_pc_reg    <= RESET_PC;
            r_buf_pc    <= '0;
            r_buf_instr <= '0;
            r_kill      <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_branch_taken)
                        r_pc_reg <= i_branch_addr;
                    if (i_imem_gnt) begin
                        r_buf_pc <= r_pc_reg;
                        r_state  <= S_WAIT;
                        // Old address already accepted: its response must be dropped.
                        if (i_branch_taken)
                            r_kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_branch_taken)
                        r_pc_reg <= i_branch_addr;
                    if (i_imem_rvalid) begin
                        if (r_kill || i_branch_taken) begin
                            r_kill  <= 1'b0;
                            r_state <= S_FETCH;
                        end else begin
                            r_buf_instr <= i_imem_rdata;
                            r_state     <= S_READY;
                        end
                    end else if (i_branch_taken) begin
                        r_kill <= 1'b1;
                    end
                end
                S_READY: begin
                    if (i_branch_taken) begin
                        r_pc_reg <= i_branch_addr;
                        r_state  <= S_FETCH;
                    end else if (!i_freeze) begin
                        // Word consumed by IF/ID on this edge.
                        r_pc_reg <= w_buf_pc_inc;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit. The bench acts as instruction memory,
//   returning dat(addr) for a fetch of addr, and checks every output against
//   hand-derived values.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'hF000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] br_addr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ivld;

    int tests = 0;
    int fails = 0;

    if_fetch_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_freeze       (freeze),
        .i_branch_taken (br),
        .i_branch_addr  (br_addr),
        .o_imem_req     (req),
        .o_imem_addr    (addr),
        .i_imem_gnt     (gnt),
        .i_imem_rvalid  (rvalid),
        .i_imem_rdata   (rdata),
        .o_pc           (pc),
        .o_instruction  (instr),
        .o_inst_valid   (ivld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word from the FETCH state with gnt immediately and rvalid one
    // cycle later; leaves the DUT in READY holding the word.
    task automatic do_fetch(input logic [31:0] a);
        tests++; if (req !== 1'b1)  begin fails++; $display("FAIL fetch_req@%h: got %b want 1", a, req); end
        tests++; if (addr !== a)    begin fails++; $display("FAIL fetch_addr: got %h want %h", addr, a); end
        tests++; if (ivld !== 1'b0) begin fails++; $display("FAIL fetch_bubble@%h: got %b want 0", a, ivld); end
        gnt = 1'b1; cyc(); gnt = 1'b0;
        tests++; if (req !== 1'b0)  begin fails++; $display("FAIL wait_req@%h: got %b want 0", a, req); end
        tests++; if (instr !== NOP) begin fails++; $display("FAIL wait_nop@%h: got %h want %h", a, instr, NOP); end
        rvalid = 1'b1; rdata = dat(a); cyc(); rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
        tests++; if (ivld !== 1'b1)     begin fails++; $display("FAIL ready_vld@%h: got %b want 1", a, ivld); end
        tests++; if (pc !== a + 32'd4)  begin fails++; $display("FAIL ready_pc@%h: got %h want %h", a, pc, a + 32'd4); end
        tests++; if (instr !== dat(a))  begin fails++; $display("FAIL ready_instr@%h: got %h want %h", a, instr, dat(a)); end
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; br = 1'b0; br_addr = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        cyc(); cyc();
        tests++; if (req !== 1'b1)  begin fails++; $display("FAIL rst_req: got %b want 1", req); end
        tests++; if (addr !== 32'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", addr); end
        tests++; if (ivld !== 1'b0) begin fails++; $display("FAIL rst_vld: got %b want 0", ivld); end
        tests++; if (instr !== NOP) begin fails++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        tests++; if (pc !== 32'd0)  begin fails++; $display("FAIL rst_pc: got %h want 0", pc); end
        rst = 1'b1;
    endtask

    // Three sequential fetches; inst_valid high exactly one cycle in three.
    task automatic test_sequential();
        int vcnt;
        for (int k = 0; k < 3; k++) begin
            vcnt = 0;
            do_fetch(32'(4 * k));
            cyc();
            tests++; if (ivld !== 1'b0) begin fails++; $display("FAIL seq_after_consume%0d: got %b want 0", k, ivld); end
        end
        tests++; if (addr !== 32'd12) begin fails++; $display("FAIL seq_next_addr: got %h want c", addr); end
    endtask

    task automatic test_freeze();
        do_fetch(32'd12);
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            tests++; if (ivld !== 1'b1)        begin fails++; $display("FAIL frz_vld%0d: got %b want 1", i, ivld); end
            tests++; if (pc !== 32'd16)        begin fails++; $display("FAIL frz_pc%0d: got %h want 10", i, pc); end
            tests++; if (instr !== dat(32'd12)) begin fails++; $display("FAIL frz_instr%0d: got %h want %h", i, instr, dat(32'd12)); end
            tests++; if (req !== 1'b0)         begin fails++; $display("FAIL frz_req%0d: got %b want 0", i, req); end
        end
        freeze = 1'b0; cyc();
        tests++; if (req !== 1'b1)     begin fails++; $display("FAIL frz_rel_req: got %b want 1", req); end
        tests++; if (addr !== 32'd16)  begin fails++; $display("FAIL frz_rel_addr: got %h want 10", addr); end
    endtask

    task automatic test_branch_wait();
        gnt = 1'b1; cyc(); gnt = 1'b0;
        br = 1'b1; br_addr = 32'h100; cyc(); br = 1'b0;
        tests++; if (ivld !== 1'b0) begin fails++; $display("FAIL bw_vld_wait: got %b want 0", ivld); end
        rvalid = 1'b1; rdata = dat(32'd16); cyc(); rvalid = 1'b0;
        tests++; if (ivld !== 1'b0)      begin fails++; $display("FAIL bw_discard_vld: got %b want 0", ivld); end
        tests++; if (instr !== NOP)      begin fails++; $display("FAIL bw_discard_instr: got %h want %h", instr, NOP); end
        do_fetch(32'h100);
        // Branch and freeze together in READY: redirect wins, bubble this cycle.
        br = 1'b1; freeze = 1'b1; br_addr = 32'h200; #1;
        tests++; if (ivld !== 1'b0)  begin fails++; $display("FAIL bf_vld: got %b want 0", ivld); end
        tests++; if (instr !== NOP)  begin fails++; $display("FAIL bf_instr: got %h want %h", instr, NOP); end
        tests++; if (pc !== 32'd0)   begin fails++; $display("FAIL bf_pc: got %h want 0", pc); end
        cyc(); br = 1'b0; freeze = 1'b0;
        tests++; if (req !== 1'b1)      begin fails++; $display("FAIL bf_req: got %b want 1", req); end
        tests++; if (addr !== 32'h200)  begin fails++; $display("FAIL bf_addr: got %h want 200", addr); end
    endtask

    task automatic test_branch_gnt();
        gnt = 1'b1; br = 1'b1; br_addr = 32'h300; cyc(); gnt = 1'b0; br = 1'b0;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL bg_wait_req: got %b want 0", req); end
        rvalid = 1'b1; rdata = dat(32'h200); cyc(); rvalid = 1'b0;
        tests++; if (ivld !== 1'b0)     begin fails++; $display("FAIL bg_drop_vld: got %b want 0", ivld); end
        tests++; if (req !== 1'b1)      begin fails++; $display("FAIL bg_refetch_req: got %b want 1", req); end
        tests++; if (addr !== 32'h300)  begin fails++; $display("FAIL bg_refetch_addr: got %h want 300", addr); end
        // Kill must be cleared: the refetched word is delivered.
        do_fetch(32'h300);
        cyc();
    endtask

    task automatic test_delayed();
        for (int i = 0; i < 4; i++) begin
            tests++; if (req !== 1'b1 || addr !== 32'h304) begin fails++; $display("FAIL dly_gnt%0d: got req %b addr %h want 1 304", i, req, addr); end
            tests++; if (ivld !== 1'b0 || instr !== NOP || pc !== 32'd0) begin fails++; $display("FAIL dly_gnt_out%0d: got %b %h %h want 0 %h 0", i, ivld, instr, pc, NOP); end
            cyc();
        end
        gnt = 1'b1; cyc(); gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (req !== 1'b0) begin fails++; $display("FAIL dly_rv_req%0d: got %b want 0", i, req); end
            tests++; if (ivld !== 1'b0 || instr !== NOP || pc !== 32'd0) begin fails++; $display("FAIL dly_rv_out%0d: got %b %h %h want 0 %h 0", i, ivld, instr, pc, NOP); end
            cyc();
        end
        rvalid = 1'b1; rdata = dat(32'h304); cyc(); rvalid = 1'b0;
        tests++; if (ivld !== 1'b1 || pc !== 32'h308 || instr !== dat(32'h304)) begin fails++; $display("FAIL dly_ready: got %b %h %h want 1 308 %h", ivld, pc, instr, dat(32'h304)); end
        cyc();
    endtask

    task automatic test_reset_mid();
        gnt = 1'b1; cyc(); gnt = 1'b0;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rm_in_wait: got %b want 0", req); end
        rst = 1'b0; #1;
        tests++; if (req !== 1'b1 || addr !== 32'd0) begin fails++; $display("FAIL rm_async: got req %b addr %h want 1 0", req, addr); end
        cyc(); rst = 1'b1;
        rvalid = 1'b1; rdata = dat(32'h308); cyc(); rvalid = 1'b0;
        tests++; if (ivld !== 1'b0)  begin fails++; $display("FAIL rm_late_rvalid: got %b want 0", ivld); end
        tests++; if (addr !== 32'd0) begin fails++; $display("FAIL rm_first_addr: got %h want 0", addr); end
        do_fetch(32'd0);
        cyc();
    endtask

    task automatic test_wrap();
        br = 1'b1; br_addr = 32'hFFFF_FFFC; cyc(); br = 1'b0;
        do_fetch(32'hFFFF_FFFC);
        cyc();
        tests++; if (addr !== 32'd0) begin fails++; $display("FAIL wrap_next_addr: got %h want 0", addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_wait();
        test_branch_gnt();
        test_delayed();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
